hand_tally_engine: RTL

//   Stores the card hand of every player as a NUM_CARDS-bit bitmap (bit i = card i held) and executes

---
 rtl/hand_tally_if.sv | 37 +++
 rtl/hand_tally_engine.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hand_tally_if.sv
// Command/result bundle for hand_tally_engine.
// master: issues cmd_*, observes cmd_ready and res_*; slave: the engine.
interface hand_tally_if #(
   parameter int NUM_CARDS   = 9,
   parameter int NUM_PLAYERS = 2
);
   localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
   localparam int IW = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1;
   localparam int CW = $clog2(NUM_CARDS + 1);

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [1:0]           cmd_op;
   logic [PW-1:0]        cmd_player;
   logic [NUM_CARDS-1:0] cmd_hand;
   logic [IW-1:0]        cmd_card;
   logic                 res_valid;
   logic [PW-1:0]        res_player;
   logic [CW-1:0]        res_black;
   logic [CW-1:0]        res_white;
   logic                 res_error;
   logic                 res_empty;

   modport master (
      output cmd_valid, cmd_op, cmd_player, cmd_hand, cmd_card,
      input  cmd_ready,
      input  res_valid, res_player, res_black, res_white,
      input  res_error, res_empty
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_player, cmd_hand, cmd_card,
      output cmd_ready,
      output res_valid, res_player, res_black, res_white,
      output res_error, res_empty
   );
endinterface

// File: rtl/hand_tally_engine.sv
// Per-player card hand store; runs DEAL/PLAY/QUERY and recounts the hand
// one bit per cycle into black (even) / white (odd) totals.
// Ports: clk, rst (sync, active high), bus (hand_tally_if.slave):
//   cmd_valid/ready/op/player/hand/card in, res_valid/player/black/white/error/empty out.
module hand_tally_engine #(
   parameter int NUM_CARDS   = 9,
   parameter int NUM_PLAYERS = 2
) (
   input  logic         clk,
   input  logic         rst,
   hand_tally_if.slave  bus
);
   localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
   localparam int IW = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1;
   localparam int CW = $clog2(NUM_CARDS + 1);

   localparam logic [1:0] OP_DEAL  = 2'b00;
   localparam logic [1:0] OP_PLAY  = 2'b01;
   localparam logic [1:0] OP_QUERY = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_APPLY,
      S_SCAN,
      S_DONE
   } state_t;

   state_t state;
   state_t state_n;

   logic [1:0]           op_q;
   logic [PW-1:0]        player_q;
   logic [NUM_CARDS-1:0] hand_q;
   logic [IW-1:0]        card_q;

   logic [NUM_CARDS-1:0] hands [NUM_PLAYERS];
   logic [NUM_CARDS-1:0] scan_q;
   logic [IW-1:0]        k_q;
   logic [CW-1:0]        black_q;
   logic [CW-1:0]        white_q;
   logic                 err_q;

   logic                 res_valid_q;
   logic [PW-1:0]        res_player_q;
   logic [CW-1:0]        res_black_q;
   logic [CW-1:0]        res_white_q;
   logic                 res_error_q;
   logic                 res_empty_q;

   logic                 accept;
   logic                 scan_last;
   logic                 player_ok;
   logic                 card_ok;
   logic [NUM_CARDS-1:0] cur_hand;
   logic [NUM_CARDS-1:0] new_hand;
   logic                 apply_err;
   logic [CW-1:0]        black_n;
   logic [CW-1:0]        white_n;

   assign bus.cmd_ready  = (state == S_IDLE);
   assign bus.res_valid  = res_valid_q;
   assign bus.res_player = res_player_q;
   assign bus.res_black  = res_black_q;
   assign bus.res_white  = res_white_q;
   assign bus.res_error  = res_error_q;
   assign bus.res_empty  = res_empty_q;

   assign accept    = bus.cmd_valid && (state == S_IDLE);
   assign scan_last = (k_q == IW'(NUM_CARDS - 1));
   assign player_ok = int'(player_q) < NUM_PLAYERS;
   assign card_ok   = int'(card_q) < NUM_CARDS;
   // An invalid player scans as an empty hand.
   assign cur_hand  = player_ok ? hands[player_q] : '0;

   // k_q[0] tells the colour of the bit currently at scan_q[0].
   assign black_n = black_q + CW'(scan_q[0] & ~k_q[0]);
   assign white_n = white_q + CW'(scan_q[0] &  k_q[0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE:  if (accept) state_n = S_APPLY;
         S_APPLY: state_n = S_SCAN;
         S_SCAN:  if (scan_last) state_n = S_DONE;
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      apply_err = 1'b0;
      new_hand  = cur_hand;
      unique case (1'b1)
         op_q == OP_DEAL: begin
            new_hand = hand_q;
         end
         op_q == OP_PLAY: begin
            if (card_ok && cur_hand[card_q]) begin
               new_hand = cur_hand & ~(NUM_CARDS'(1) << card_q);
            end else begin
               apply_err = 1'b1;
            end
         end
         op_q == OP_QUERY: begin
            new_hand = cur_hand;
         end
         default: begin
            apply_err = 1'b1;
         end
      endcase
      if (!player_ok) apply_err = 1'b1;
      // A rejected command leaves the hand exactly as it was.
      if (apply_err) new_hand = cur_hand;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q         <= '0;
         player_q     <= '0;
         hand_q       <= '0;
         card_q       <= '0;
         scan_q       <= '0;
         k_q          <= '0;
         black_q      <= '0;
         white_q      <= '0;
         err_q        <= 1'b0;
         res_valid_q  <= 1'b0;
         res_player_q <= '0;
         res_black_q  <= '0;
         res_white_q  <= '0;
         res_error_q  <= 1'b0;
         res_empty_q  <= 1'b0;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            hands[i] <= '0;
         end
      end else begin
         res_valid_q <= 1'b0;

         if (accept) begin
            op_q     <= bus.cmd_op;
            player_q <= bus.cmd_player;
            hand_q   <= bus.cmd_hand;
            card_q   <= bus.cmd_card;
         end

         if (state == S_APPLY) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
               if (player_ok && int'(player_q) == i) begin
                  hands[i] <= new_hand;
               end
            end
            scan_q  <= new_hand;
            k_q     <= '0;
            black_q <= '0;
            white_q <= '0;
            err_q   <= apply_err;
         end

         if (state == S_SCAN) begin
            scan_q  <= scan_q >> 1;
            k_q     <= k_q + IW'(1);
            black_q <= black_n;
            white_q <= white_n;
            // Final counts go straight to the result registers so they
            // are visible during the single DONE cycle.
            if (scan_last) begin
               res_valid_q  <= 1'b1;
               res_player_q <= player_q;
               res_black_q  <= black_n;
               res_white_q  <= white_n;
               res_error_q  <= err_q;
               res_empty_q  <= (black_n == '0) && (white_n == '0);
            end
         end
      end
   end
endmodule
